// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I fetch sequencer; owns the PC, issues one outstanding
// imem request at a time and hands each instruction to decode via valid/ready.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   PCSel, from_alu     redirect request and target
//   imem_req/addr       fetch request (level) and address
//   imem_rvalid/rdata   one response per request
//   inst_valid/ready    handshake towards decode
//   inst, pc_out        fetched word and its address
//   pc_plus_4           pc_out + 4 (wraps)
//   misaligned          sticky: redirect target not word aligned
module fetch_ctrl #(
  parameter int PC_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PCSel,
  input  logic [PC_WIDTH-1:0]          from_alu,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INSTRUCTION_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic [PC_WIDTH-1:0]          pc_plus_4,
  output logic                         misaligned
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN,
    HALT
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic                busy;
  logic                bad;

  assign bad       = |from_alu[1:0];
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign pc_plus_4 = pc + PC_WIDTH'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      busy       <= 1'b0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      misaligned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          busy     <= 1'b1;
        end
        REQ: begin
          if (PCSel) begin
            pc <= from_alu;
            if (bad) begin
              state      <= HALT;
              imem_req   <= 1'b0;
              misaligned <= 1'b1;
              busy       <= !imem_rvalid;
            end else if (!imem_rvalid) begin
              // old response still owed: wait for it
              state    <= DRAIN;
              imem_req <= 1'b0;
            end
            // redirect with response: reissue at new pc
          end else if (imem_rvalid) begin
            inst       <= imem_rdata;
            state      <= HOLD;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end
        DRAIN: begin
          if (PCSel) pc <= from_alu;
          if (PCSel && bad) begin
            state      <= HALT;
            misaligned <= 1'b1;
            busy       <= !imem_rvalid;
          end else if (imem_rvalid) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        HOLD: begin
          if (PCSel || inst_ready) begin
            inst_valid <= 1'b0;
            pc <= PCSel ? from_alu
                        : pc + PC_WIDTH'(4);
            if (PCSel && bad) begin
              state      <= HALT;
              misaligned <= 1'b1;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        HALT: begin
          // swallow any response still in flight
          if (busy && imem_rvalid) busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed + random bench for fetch_ctrl
// against a transaction-level reference model and a latency-random memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSel = 1'b0;
  logic [31:0] from_alu = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4;
  logic        misaligned;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PC_WIDTH(32),
    .INSTRUCTION_WIDTH(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PCSel(PCSel),
    .from_alu(from_alu),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .pc_out(pc_out),
    .pc_plus_4(pc_plus_4),
    .misaligned(misaligned)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: one pending request, latency fixed or random
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_addr;
  int          lat_mode = 0;

  task automatic mem_drive();
    if (m_pend && imem_rvalid) m_pend = 0;
    imem_rvalid = 1'b0;
    if (!m_pend && imem_req === 1'b1) begin
      m_pend = 1;
      m_addr = imem_addr;
      m_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end
    if (m_pend) begin
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = m_addr ^ 32'hA5A5_0000;
      end else begin
        m_cnt--;
      end
    end
  endtask

  // reference model: fetch intent, owed stale response, presented word
  bit          md_boot, md_want, md_stale, md_valid, md_halt, md_mis;
  logic [31:0] md_pc, md_inst;

  task automatic model_reset();
    md_boot = 1; md_want = 0; md_stale = 0;
    md_valid = 0; md_halt = 0; md_mis = 0;
    md_pc = 32'h0; md_inst = 32'h0;
  endtask

  task automatic redirect(logic [31:0] t, bit owed);
    md_pc = t;
    if (t[1:0] != 2'b00) begin
      md_halt = 1; md_mis = 1; md_want = 0; md_stale = 0;
    end else begin
      md_want = 1; md_stale = owed;
    end
  endtask

  task automatic model_step();
    if (md_halt) return;
    if (md_boot) begin
      md_boot = 0; md_want = 1;
      return;
    end
    if (md_valid) begin
      if (PCSel) begin
        md_valid = 0;
        redirect(from_alu, 0);
      end else if (inst_ready) begin
        md_valid = 0;
        md_pc = md_pc + 32'd4;
        md_want = 1;
      end
      return;
    end
    if (PCSel) begin
      redirect(from_alu, !imem_rvalid);
    end else if (imem_rvalid) begin
      if (md_stale) md_stale = 0;
      else begin
        md_inst = imem_rdata;
        md_valid = 1;
        md_want = 0;
      end
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !md_boot && !md_halt && md_want && !md_stale;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, md_pc);
    chk("inst_valid", inst_valid, md_valid);
    if (md_valid) chk("inst", inst, md_inst);
    chk("pc_out", pc_out, md_pc);
    chk("pc_plus_4", pc_plus_4, md_pc + 32'd4);
    chk("misaligned", misaligned, md_mis);
  endtask

  task automatic settle();
    @(negedge clk);
    compare();
    mem_drive();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    settle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    PCSel = 1'b0;
    inst_ready = 1'b0;
    imem_rvalid = 1'b0;
    m_pend = 0;
    model_reset();
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_pc4", pc_plus_4, 4);
    chk("rst_mis", misaligned, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    settle();
  endtask

  int halt_cycles;

  initial begin
    @(negedge clk);
    do_reset();
    chk("idle_req", imem_req, 0);
    lat_mode = 0;
    inst_ready = 1'b1;
    cycle();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    cycle();
    chk("h0_valid", inst_valid, 1);
    chk("h0_inst", inst, 32'hA5A5_0000);
    cycle();
    chk("r4_addr", imem_addr, 32'h4);
    chk("r4_valid", inst_valid, 0);
    inst_ready = 1'b0;
    cycle();
    chk("h4_pc", pc_out, 32'h4);
    chk("h4_pc4", pc_plus_4, 32'h8);
    chk("h4_inst", inst, 32'hA5A5_0004);
    repeat (3) begin
      cycle();
      chk("bp_pc", pc_out, 32'h4);
      chk("bp_req", imem_req, 0);
      chk("bp_valid", inst_valid, 1);
    end
    inst_ready = 1'b1;
    cycle();
    chk("r8_addr", imem_addr, 32'h8);
    cycle();
    chk("h8_pc", pc_out, 32'h8);
    PCSel = 1'b1;
    from_alu = 32'h20;
    cycle();
    chk("prio_addr", imem_addr, 32'h20);
    PCSel = 1'b0;
    cycle();
    chk("h20_inst", inst, 32'hA5A5_0020);

    lat_mode = 3;
    cycle();
    chk("r24_addr", imem_addr, 32'h24);
    cycle();
    chk("r24_wait", imem_req, 1);
    PCSel = 1'b1;
    from_alu = 32'hC;
    cycle();
    chk("drain_req", imem_req, 0);
    PCSel = 1'b0;
    cycle();
    chk("drain_valid", inst_valid, 0);
    lat_mode = 0;
    cycle();
    chk("rc_addr", imem_addr, 32'hC);
    chk("rc_req", imem_req, 1);
    cycle();
    chk("hc_pc", pc_out, 32'hC);
    chk("hc_inst", inst, 32'hA5A5_000C);

    lat_mode = 2;
    cycle();
    chk("r10_addr", imem_addr, 32'h10);
    cycle();
    cycle();
    chk("r10_rvalid", imem_rvalid, 1);
    PCSel = 1'b1;
    from_alu = 32'h30;
    lat_mode = 0;
    cycle();
    chk("coin_req", imem_req, 1);
    chk("coin_addr", imem_addr, 32'h30);
    chk("coin_valid", inst_valid, 0);
    PCSel = 1'b0;
    cycle();
    chk("h30_pc", pc_out, 32'h30);

    PCSel = 1'b1;
    from_alu = 32'hFFFF_FFFC;
    cycle();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    PCSel = 1'b0;
    cycle();
    chk("wrap_pc4", pc_plus_4, 32'h0);
    cycle();
    chk("wrap_next", imem_addr, 32'h0);
    cycle();

    PCSel = 1'b1;
    from_alu = 32'hE;
    cycle();
    chk("mis_flag", misaligned, 1);
    chk("mis_pc", pc_out, 32'hE);
    from_alu = 32'h40;
    repeat (3) begin
      cycle();
      chk("halt_req", imem_req, 0);
      chk("halt_valid", inst_valid, 0);
      chk("halt_pc", pc_out, 32'hE);
    end
    do_reset();
    cycle();
    chk("restart_addr", imem_addr, 32'h0);

    lat_mode = -1;
    halt_cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      PCSel = ($urandom_range(0, 7) == 0);
      from_alu = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0)
        from_alu = from_alu | 32'($urandom_range(1, 3));
      halt_cycles = md_halt ? halt_cycles + 1 : 0;
      if (halt_cycles > 4 || $urandom_range(0, 399) == 0) begin
        halt_cycles = 0;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
